image_stream_tx: RTL and testbench

Frame-source serializer for the image-processing pipeline. It reads a WIDTH×HEIGHT frame of packed 24-bit RGB pixels from an external pixel memory in raster order and emits it as a byte stream, R then G then B per pixel, one byte per accepted handshake. A one-pixel prefetch keeps the stream gapless while the sink holds ready high. It drives the input side of the blur/filter blocks and generates a frame-start pulse for them.

---
 rtl/image_stream_tx.sv | 204 ++++++++++++++++++++
 tb/tb_image_stream_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/image_stream_tx.sv
// image_stream_tx: serialises a WIDTH x HEIGHT frame of packed RGB pixels,
// read from an external pixel memory in raster order, into a byte stream
// (R, G, B per pixel). A one-pixel prefetch keeps the stream gapless while
// the sink holds byte_ready high.
//
// Optional feature macro: IMAGE_TX_CHECKSUM_EN adds a 16-bit running sum
// of the transferred bytes on the checksum port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start after reset
// S_FETCH | first pixel read issued (pix_rd high), frame_start pulse
// S_SEND  | streaming bytes of the current pixel
// S_DONE  | frame fully sent, done held until the next start

module image_stream_tx #(
    parameter int WIDTH  = 350,
    parameter int HEIGHT = 350,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              pix_rd,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [23:0]       pix_rdata,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              frame_start,
    output logic              busy,
    output logic              done
`ifdef IMAGE_TX_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] PH_R = 2'd0;
    localparam logic [1:0] PH_G = 2'd1;
    localparam logic [1:0] PH_B = 2'd2;

    state_t              state_q, state_d;
    logic [1:0]          phase_q;
    logic [COL_W-1:0]    col_q;
    logic [ROW_W-1:0]    row_q;
    logic [ADDR_W-1:0]   cur_idx_q;
    logic [23:0]         out_pix_q;
    logic                out_empty_q;   // first pixel not yet captured; forward pix_rdata
    logic [23:0]         pf_data_q;
    logic                pf_valid_q;
    logic                rd_arr_q;      // read data is on pix_rdata this cycle
    logic [23:0]         cur_word;
    logic                launch;
    logic                xfer;
    logic                last_pix;

    assign launch   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign xfer     = (state_q == S_SEND) && byte_ready;
    assign last_pix = (row_q == ROW_W'(HEIGHT - 1)) && (col_q == COL_W'(WIDTH - 1));
    assign cur_word = out_empty_q ? pix_rdata : out_pix_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_d     = state_q;
        byte_valid  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        frame_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                busy        = 1'b1;
                frame_start = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                busy       = 1'b1;
                byte_valid = 1'b1;
                if (xfer && (phase_q == PH_B) && last_pix) state_d = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Byte select for the current phase.
    always_comb begin
        byte_out = cur_word[7:0];
        case (phase_q)
            PH_R:    byte_out = cur_word[23:16];
            PH_G:    byte_out = cur_word[15:8];
            default: byte_out = cur_word[7:0];
        endcase
    end

    // Read issue, pixel position, output/prefetch registers and byte phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_rd      <= 1'b0;
            pix_addr    <= '0;
            rd_arr_q    <= 1'b0;
            phase_q     <= PH_R;
            col_q       <= '0;
            row_q       <= '0;
            cur_idx_q   <= '0;
            out_pix_q   <= '0;
            out_empty_q <= 1'b0;
            pf_data_q   <= '0;
            pf_valid_q  <= 1'b0;
        end else begin
            rd_arr_q <= pix_rd;
            pix_rd   <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pix_rd      <= 1'b1;
                        pix_addr    <= '0;
                        phase_q     <= PH_R;
                        col_q       <= '0;
                        row_q       <= '0;
                        cur_idx_q   <= '0;
                        pf_valid_q  <= 1'b0;
                        out_empty_q <= 1'b1;
                    end
                end
                S_SEND: begin
                    // The first word lands during the first SEND cycle and is
                    // forwarded combinationally until it is registered here.
                    if (rd_arr_q && out_empty_q) begin
                        out_pix_q   <= pix_rdata;
                        out_empty_q <= 1'b0;
                    end else if (rd_arr_q && !(xfer && (phase_q == PH_B))) begin
                        pf_data_q  <= pix_rdata;
                        pf_valid_q <= 1'b1;
                    end
                    if (xfer) begin
                        case (phase_q)
                            PH_R: begin
                                phase_q <= PH_G;
                                if (!last_pix) begin
                                    pix_rd   <= 1'b1;
                                    pix_addr <= cur_idx_q + ADDR_W'(1);
                                end
                            end
                            PH_G: phase_q <= PH_B;
                            default: begin
                                phase_q <= PH_R;
                                if (!last_pix) begin
                                    cur_idx_q <= cur_idx_q + ADDR_W'(1);
                                    if (col_q == COL_W'(WIDTH - 1)) begin
                                        col_q <= '0;
                                        row_q <= row_q + ROW_W'(1);
                                    end else begin
                                        col_q <= col_q + COL_W'(1);
                                    end
                                    // Prefetch arriving on this same edge bypasses the register.
                                    if (pf_valid_q) begin
                                        out_pix_q  <= pf_data_q;
                                        pf_valid_q <= 1'b0;
                                    end else begin
                                        out_pix_q <= pix_rdata;
                                    end
                                end
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IMAGE_TX_CHECKSUM_EN
    // Running modulo-2^16 sum of transferred bytes, cleared at frame start.
    always_ff @(posedge clk) begin
        if (reset)     checksum <= '0;
        else if (launch) checksum <= '0;
        else if (xfer) checksum <= checksum + {8'h00, byte_out};
    end
`endif

endmodule

// File: tb/tb_image_stream_tx.sv
// Directed bench for image_stream_tx: a 4x2 frame under several sink
// patterns (including restart and mid-frame reset) and a 1x1 frame.
// Checksum checks are compiled in when IMAGE_TX_CHECKSUM_EN is defined.

module tb_image_stream_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a, ready_a, start_b, ready_b;

    logic       pix_rd_a, byte_valid_a, frame_start_a, busy_a, done_a;
    logic [3:0] pix_addr_a;
    logic [23:0] pix_rdata_a = '0;
    logic [7:0] byte_out_a;

    logic       pix_rd_b, byte_valid_b, frame_start_b, busy_b, done_b;
    logic [0:0] pix_addr_b;
    logic [23:0] pix_rdata_b = '0;
    logic [7:0] byte_out_b;
`ifdef IMAGE_TX_CHECKSUM_EN
    logic [15:0] checksum_a, checksum_b;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    image_stream_tx #(.WIDTH(4), .HEIGHT(2), .ADDR_W(4)) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .pix_rd(pix_rd_a), .pix_addr(pix_addr_a), .pix_rdata(pix_rdata_a),
        .byte_out(byte_out_a), .byte_valid(byte_valid_a), .byte_ready(ready_a),
        .frame_start(frame_start_a), .busy(busy_a), .done(done_a)
`ifdef IMAGE_TX_CHECKSUM_EN
        , .checksum(checksum_a)
`endif
    );

    image_stream_tx #(.WIDTH(1), .HEIGHT(1), .ADDR_W(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .pix_rd(pix_rd_b), .pix_addr(pix_addr_b), .pix_rdata(pix_rdata_b),
        .byte_out(byte_out_b), .byte_valid(byte_valid_b), .byte_ready(ready_b),
        .frame_start(frame_start_b), .busy(busy_b), .done(done_b)
`ifdef IMAGE_TX_CHECKSUM_EN
        , .checksum(checksum_b)
`endif
    );

    // Pixel memories: word i = {i, i+0x10, i+0x20}; 1x1 frame holds FF8001.
    always @(posedge clk) begin
        if (pix_rd_a) pix_rdata_a <= {4'h0, pix_addr_a, 4'h1, pix_addr_a, 4'h2, pix_addr_a};
        if (pix_rd_b) pix_rdata_b <= 24'hFF8001;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stream monitor for the 4x2 instance.
    logic [7:0] got_q[$];
    logic [3:0] rd_addr_q[$];
    logic [7:0] got_b[$];
    int cyc = 0, start_cyc = 0, first_cyc = 0, last_cyc = 0;
    int fs_cnt = 0, stall_err = 0, drop_cnt = 0;
    bit prev_stall = 0, prev_valid = 0;
    logic [7:0] prev_byte = '0;

    always @(posedge clk) begin
        if (reset) begin
            prev_stall = 0;
            prev_valid = 0;
        end else begin
            if (byte_valid_a && ready_a) begin
                got_q.push_back(byte_out_a);
                if (got_q.size() == 1) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (pix_rd_a) rd_addr_q.push_back(pix_addr_a);
            if (frame_start_a) fs_cnt++;
            if (start_a && !busy_a) start_cyc = cyc;
            if (prev_stall && byte_out_a != prev_byte) stall_err++;
            if (prev_valid && !byte_valid_a && !done_a) drop_cnt++;
            prev_stall = byte_valid_a && !ready_a;
            prev_byte  = byte_out_a;
            prev_valid = byte_valid_a;
            if (byte_valid_b && ready_b) got_b.push_back(byte_out_b);
        end
        cyc++;
    end

    // mode 0: ready always high, 1: ready toggles 1-0-1-0, 2: random stalls.
    task automatic run_frame(input int mode, input bit restart_mid, input string nm);
        int exp_sum;
        logic [7:0] exp_b;
        got_q.delete();
        rd_addr_q.delete();
        fs_cnt = 0; stall_err = 0; drop_cnt = 0;
        @(negedge clk);
        start_a = 1'b1;
        ready_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk({nm, "_fs"},     frame_start_a, 1);
        chk({nm, "_rd"},     pix_rd_a, 1);
        chk({nm, "_addr0"},  pix_addr_a, 0);
        chk({nm, "_busy"},   busy_a, 1);
        chk({nm, "_vld0"},   byte_valid_a, 0);
        for (int c = 0; c < 400 && !done_a; c++) begin
            case (mode)
                0:       ready_a = 1'b1;
                1:       ready_a = (c % 2 == 0);
                default: ready_a = 1'($urandom_range(0, 1));
            endcase
            start_a = restart_mid && (got_q.size() == 5);
            @(negedge clk);
        end
        start_a = 1'b0;
        chk({nm, "_done"},   done_a, 1);
        chk({nm, "_idle"},   busy_a, 0);
        chk({nm, "_vldend"}, byte_valid_a, 0);
        chk({nm, "_nbytes"}, got_q.size(), 24);
        exp_sum = 0;
        for (int b = 0; b < 24 && b < got_q.size(); b++) begin
            exp_b = 8'((b / 3) + 16 * (b % 3));
            exp_sum += exp_b;
            chk($sformatf("%s_byte%0d", nm, b), got_q[b], exp_b);
        end
        chk({nm, "_nrd"}, rd_addr_q.size(), 8);
        for (int i = 0; i < 8 && i < rd_addr_q.size(); i++)
            chk($sformatf("%s_rdaddr%0d", nm, i), rd_addr_q[i], i);
        chk({nm, "_fscnt"}, fs_cnt, 1);
        chk({nm, "_stall"}, stall_err, 0);
        chk({nm, "_drop"},  drop_cnt, 0);
        if (mode == 0) begin
            chk({nm, "_lat"},     first_cyc - start_cyc, 2);
            chk({nm, "_gapless"}, last_cyc - first_cyc, 23);
            chk({nm, "_donelat"}, cyc - last_cyc, 1);
        end
`ifdef IMAGE_TX_CHECKSUM_EN
        chk({nm, "_csum"}, checksum_a, exp_sum);
`endif
    endtask

    initial begin
        reset = 1'b1; start_a = 1'b0; ready_a = 1'b0; start_b = 1'b0; ready_b = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_rd",    pix_rd_a, 0);
        chk("rst_addr",  pix_addr_a, 0);
        chk("rst_byte",  byte_out_a, 0);
        chk("rst_vld",   byte_valid_a, 0);
        chk("rst_fs",    frame_start_a, 0);
        chk("rst_busy",  busy_a, 0);
        chk("rst_done",  done_a, 0);
`ifdef IMAGE_TX_CHECKSUM_EN
        chk("rst_csum",  checksum_a, 0);
`endif

        run_frame(0, 1'b0, "rdy");
        run_frame(1, 1'b0, "tog");
        run_frame(2, 1'b1, "rnd");

        // Reset while pixel 3 is being sent, with its prefetch in flight.
        @(negedge clk);
        start_a = 1'b1; ready_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        got_q.delete();
        for (int c = 0; c < 100 && got_q.size() < 9; c++) @(negedge clk);
        chk("mid_reached", got_q.size(), 9);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_rd",   pix_rd_a, 0);
        chk("mrst_addr", pix_addr_a, 0);
        chk("mrst_byte", byte_out_a, 0);
        chk("mrst_vld",  byte_valid_a, 0);
        chk("mrst_fs",   frame_start_a, 0);
        chk("mrst_busy", busy_a, 0);
        chk("mrst_done", done_a, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_idle", busy_a | done_a, 0);
        run_frame(0, 1'b0, "post");

        // Single-pixel frame.
        got_b.delete();
        @(negedge clk);
        start_b = 1'b1; ready_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int c = 0; c < 20 && !done_b; c++) @(negedge clk);
        chk("one_done", done_b, 1);
        chk("one_n", got_b.size(), 3);
        if (got_b.size() == 3) begin
            chk("one_r", got_b[0], 8'hFF);
            chk("one_g", got_b[1], 8'h80);
            chk("one_b", got_b[2], 8'h01);
        end
        chk("one_nrd_busy", busy_b, 0);
`ifdef IMAGE_TX_CHECKSUM_EN
        chk("one_csum", checksum_b, 16'h0180);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
